shift_exec_unit: RTL and testbench

Two-stage pipelined shift execution unit for the 32-bit datapath ALU path. It accepts shift operations from issue over a valid/ready handshake and registers the operands in stage 1. Stage 2 computes the result through a log-stage barrel core (1/2/4/8/16) and holds it for writeback, also over valid/ready. The unit handles full backpressure, flush, and completed-operation counting.

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_exec_unit_if.sv | 32 +++
 rtl/shift_exec_unit_core.sv | 35 +++
 rtl/shift_exec_unit.sv | 88 ++++++++
 tb/tb_shift_exec_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the pipelined shift execution unit.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;
  localparam int TAG_W  = 4;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_SRL = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  // Operand bundle captured in stage 1.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    shift_op_e         op;
    logic [TAG_W-1:0]  tag;
  } s1_payload_t;

endpackage

// File: rtl/shift_exec_unit_if.sv
// Issue/writeback bundle of the shift unit; master is the issue/writeback side,
// slave is the unit itself.
interface shift_exec_unit_if
  import shift_pkg::*;
#(
  parameter int TAG_W = shift_pkg::TAG_W,
  parameter int CNT_W = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [AMT_W-1:0]  in_amt;
  logic [1:0]        in_op;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;
  logic [CNT_W-1:0]  op_count;

  modport slave (
    input  flush, in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err, op_count
  );

  modport master (
    output flush, in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err, op_count
  );
endinterface

// File: rtl/shift_exec_unit_core.sv
// Combinational five-level barrel shifter (1/2/4/8/16) selected by op.
// SHIFT_ROR_EN enables rotate-right on op 11; otherwise op 11 passes data and flags err.
module shift_core
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  input  shift_op_e         op,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    result = data;
    err    = 1'b0;
    for (int i = 0; i < AMT_W; i++) begin
      if (amt[i]) begin
        case (op)
          OP_SLL:  result = result << (1 << i);
          OP_SRL:  result = result >> (1 << i);
          OP_SRA:  result = $signed(result) >>> (1 << i);
`ifdef SHIFT_ROR_EN
          OP_ROR:  result = (result >> (1 << i)) | (result << (DATA_W - (1 << i)));
`endif
          default: ;
        endcase
      end
    end
`ifndef SHIFT_ROR_EN
    err = (op == OP_ROR);
`endif
  end

endmodule

// File: rtl/shift_exec_unit.sv
// Two-stage shift pipeline: stage 1 registers operands, stage 2 shifts and holds
// the result for writeback. Optional rotate support via SHIFT_ROR_EN.
module shift_exec_unit
  import shift_pkg::*;
#(
  parameter int TAG_W = shift_pkg::TAG_W,
  parameter int CNT_W = 16
)(
  input  logic              clock,
  input  logic              reset,
  shift_exec_unit_if.slave  bus
);

  s1_payload_t       s1_q;
  logic              s1_valid;
  logic              s2_valid;
  logic [DATA_W-1:0] out_data_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic              out_err_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] core_result;
  logic              core_err;

  logic s2_adv, s1_adv, accept, drain;

  // Stage 1 can refill in the same cycle stage 2 drains, so no bubble appears.
  assign s2_adv = ~s2_valid | bus.out_ready;
  assign s1_adv = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv & ~bus.flush & reset;
  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = s2_valid & bus.out_ready & ~bus.flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      s1_valid <= accept;
    end
  end

  // NOTE: the operand payload needs no reset; s1_valid alone qualifies it.
  always_ff @(posedge clock) begin
    if (accept) begin
      s1_q <= '{data: bus.in_data, amt: bus.in_amt,
                op: shift_op_e'(bus.in_op), tag: bus.in_tag};
    end
  end

  shift_core u_core (
    .data   (s1_q.data),
    .amt    (s1_q.amt),
    .op     (s1_q.op),
    .result (core_result),
    .err    (core_err)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid   <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
      out_err_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      if (bus.flush) begin
        s2_valid <= 1'b0;
      end else if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data_q <= core_result;
          out_tag_q  <= s1_q.tag;
          out_err_q  <= core_err;
        end
      end
      if (drain) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_err   = out_err_q;
  assign bus.op_count  = count_q;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Directed self-checking bench for shift_exec_unit; expected values are hand-computed.
module tb_shift_exec_unit;
  import shift_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  shift_exec_unit_if bus ();

  shift_exec_unit dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d,
                       input logic [4:0] amt, input logic [3:0] tag);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_amt   = amt;
    bus.in_tag   = tag;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);

    // Reset state
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_out_tag",   bus.out_tag,   0);
    check("rst_out_err",   bus.out_err,   0);
    check("rst_op_count",  bus.op_count,  0);
    check("rst_in_ready",  bus.in_ready,  0);
    tick(); tick();
    #2 rst_n = 1'b1;
    #1;
    check("rel_in_ready", bus.in_ready, 1);
    tick();

    // SRA 0x80000000 >>> 31, two edges from presentation to out_valid
    bus.out_ready = 1'b1;
    drive(1'b1, OP_SRA, 32'h8000_0000, 5'd31, 4'd5);
    check("sra_in_ready", bus.in_ready, 1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
    check("sra_not_yet", bus.out_valid, 0);
    tick();
    check("sra_valid", bus.out_valid, 1);
    check("sra_data",  bus.out_data, 32'hFFFF_FFFF);
    check("sra_tag",   bus.out_tag, 5);
    check("sra_err",   bus.out_err, 0);
    tick();
    check("sra_count", bus.op_count, 1);
    check("sra_drained", bus.out_valid, 0);

    // Back-to-back SLL 1 << k, k = 0..31
    begin
      int rx;
      rx = 0;
      for (int k = 0; k <= 32; k++) begin
        if (k < 32) begin
          drive(1'b1, OP_SLL, 32'h1, 5'(k), 4'(k));
          check("b2b_in_ready", bus.in_ready, 1);
        end else begin
          drive(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        end
        tick();
        if (k >= 1) begin
          check("b2b_valid", bus.out_valid, 1);
          check("b2b_data", bus.out_data, 32'd1 << rx);
          rx++;
        end
      end
      tick();
      check("b2b_count", bus.op_count, 33);
      check("b2b_idle", bus.out_valid, 0);
    end

    // Fill under backpressure, then drain in order
    bus.out_ready = 1'b0;
    drive(1'b1, OP_SRL, 32'h0000_00F0, 5'd4, 4'd1);
    check("fill_rdy_a", bus.in_ready, 1);
    tick();
    drive(1'b1, OP_SLL, 32'h0000_0003, 5'd1, 4'd2);
    check("fill_rdy_b", bus.in_ready, 1);
    tick();
    drive(1'b1, OP_SRA, 32'h8000_0010, 5'd4, 4'd3);
    check("fill_rdy_c", bus.in_ready, 0);
    check("fill_a_data", bus.out_data, 32'h0000_000F);
    tick();
    check("stall_data", bus.out_data, 32'h0000_000F);
    check("stall_tag",  bus.out_tag, 1);
    check("stall_valid", bus.out_valid, 1);
    check("stall_rdy",  bus.in_ready, 0);
    bus.out_ready = 1'b1;
    #1;
    check("drain_rdy", bus.in_ready, 1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
    check("drain_b_data", bus.out_data, 32'h0000_0006);
    check("drain_b_tag",  bus.out_tag, 2);
    tick();
    check("drain_c_data", bus.out_data, 32'hF800_0001);
    check("drain_c_tag",  bus.out_tag, 3);
    tick();
    check("drain_idle",  bus.out_valid, 0);
    check("drain_count", bus.op_count, 36);

    // Flush during a full stall
    bus.out_ready = 1'b0;
    drive(1'b1, OP_SLL, 32'h1, 5'd3, 4'd7);
    tick();
    drive(1'b1, OP_SLL, 32'h1, 5'd4, 4'd8);
    tick();
    check("pre_flush_valid", bus.out_valid, 1);
    bus.flush = 1'b1;
    drive(1'b1, OP_SLL, 32'h1, 5'd5, 4'd9);
    bus.out_ready = 1'b1;
    #1;
    check("flush_in_ready", bus.in_ready, 0);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
    check("flush_valid", bus.out_valid, 0);
    check("flush_count", bus.op_count, 36);
    tick(); tick();
    check("flush_gone",  bus.out_valid, 0);
    check("flush_count2", bus.op_count, 36);

    // Op 11 with data 0xF, amount 4
    drive(1'b1, OP_ROR, 32'h0000_000F, 5'd4, 4'd9);
    tick();
    drive(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
    tick();
    check("ror_valid", bus.out_valid, 1);
`ifdef SHIFT_ROR_EN
    check("ror_data", bus.out_data, 32'hF000_0000);
    check("ror_err",  bus.out_err, 0);
`else
    check("ror_data", bus.out_data, 32'h0000_000F);
    check("ror_err",  bus.out_err, 1);
`endif
    tick();
    check("ror_count", bus.op_count, 37);

    // Asynchronous reset between edges, then a fresh SRL
    bus.out_ready = 1'b0;
    drive(1'b1, OP_SLL, 32'h1, 5'd1, 4'd6);
    tick();
    drive(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
    tick();
    check("mid_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_data",  bus.out_data, 0);
    check("arst_tag",   bus.out_tag, 0);
    check("arst_count", bus.op_count, 0);
    check("arst_rdy",   bus.in_ready, 0);
    tick();
    #3 rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    drive(1'b1, OP_SRL, 32'hF000_0000, 5'd4, 4'd4);
    tick();
    drive(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
    check("post_rst_early", bus.out_valid, 0);
    tick();
    check("post_rst_valid", bus.out_valid, 1);
    check("post_rst_data",  bus.out_data, 32'h0F00_0000);
    check("post_rst_tag",   bus.out_tag, 4);
    tick();
    check("post_rst_count", bus.op_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
